// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state codes and
// requester owner IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker. Bit 0 of req is the CPU, bit 1 the loader.
// A lone requester always wins; on a tie the side not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_id,
    output logic       grant_valid
);

    // Pure combinational pick; the caller owns the last-owner state
    always_comb begin
        grant_valid = |req;
        grant_id    = OWN_CPU;
        if (&req) begin
            grant_id = ~last;
        end else if (req[1]) begin
            grant_id = OWN_LD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a boot-loader port onto one synchronous-read
// memory. One transaction at a time, fixed 3-cycle latency:
// grant edge -> ACCESS (mem_en) -> RESP (ready pulse) -> IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    // Loader port
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ready,
    input  logic              ld_excl,
    // Memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Port-indexed views of the two requesters (index = owner ID)
    logic [1:0]             elig_vec;
    logic [1:0]             we_vec;
    logic [1:0][ADDR_W-3:0] word_vec;
    logic [1:0][DATA_W-1:0] wdata_vec;
    logic [1:0][DATA_W-1:0] rdata_vec;

    assign elig_vec     = {ld_req, cpu_req & ~ld_excl};
    assign we_vec       = {ld_we, cpu_we};
    assign word_vec[0]  = cpu_addr[ADDR_W-1:2];
    assign word_vec[1]  = ld_addr[ADDR_W-1:2];
    assign wdata_vec[0] = cpu_wdata;
    assign wdata_vec[1] = ld_wdata;

    // Byte-offset bits are ignored: memory is word addressed
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[1:0], ld_addr[1:0]};

    state_t              state_reg;
    logic                owner_reg;
    logic                last_owner_reg;
    logic                we_reg;
    logic [ADDR_W-3:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                mem_en_reg;
    logic                mem_we_reg;
    logic [1:0]          ready_reg;

    logic                grant_id;
    logic                grant_valid;

    rr_pick2 u_pick (
        .req         (elig_vec),
        .last        (last_owner_reg),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Arbiter FSM: latch the winner's operands, strobe memory, pulse ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_CPU;
            last_owner_reg <= OWN_LD;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            ready_reg      <= 2'b00;
        end else begin
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            ready_reg  <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg      <= grant_id;
                        last_owner_reg <= grant_id;
                        we_reg         <= we_vec[grant_id];
                        addr_reg       <= word_vec[grant_id];
                        wdata_reg      <= wdata_vec[grant_id];
                        mem_en_reg     <= 1'b1;
                        mem_we_reg     <= we_vec[grant_id];
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready_reg[owner_reg] <= 1'b1;
                    state_reg            <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Per-port read-data holding registers. The memory's read data only
    // arrives during RESP, so the completing read is forwarded straight
    // from mem_rdata while ready is high and captured for later cycles.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] hold_reg;

            // Capture on a read completion; writes leave the value alone
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_reg <= '0;
                end else if (ready_reg[gi] && !we_reg) begin
                    hold_reg <= mem_rdata;
                end
            end

            assign rdata_vec[gi] = (ready_reg[gi] && !we_reg) ? mem_rdata : hold_reg;
        end
    endgenerate

    assign cpu_ready = ready_reg[0];
    assign ld_ready  = ready_reg[1];
    assign cpu_rdata = rdata_vec[0];
    assign ld_rdata  = rdata_vec[1];
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions,
// then hand-written tie, alternation, exclusive-mode and reset-abort runs.
// Completions are checked against a scoreboard queue filled at drive time.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_ready;
    logic              ld_excl = 1'b0;
    logic              mem_en, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ready(ld_ready), .ld_excl(ld_excl),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory content is a fixed function of the word index
    function automatic logic [31:0] mem_pat(input logic [29:0] w);
        if (w == 30'd4) return 32'hDEAD_BEEF;
        return 32'h5A00_0000 ^ {2'b00, w};
    endfunction

    // Synchronous-read memory: data valid the cycle after mem_en, junk otherwise
    always @(posedge clk) begin
        mem_rdata <= mem_en ? mem_pat(mem_addr) : 32'hBAD0_BAD0;
    end

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    exp_t        sbq[$];
    logic [31:0] hold_exp [2];
    int          checks = 0;
    int          passes = 0;
    int          ready_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected completion for a transaction about to be issued
    task automatic expect_txn(input logic port, input logic we, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        if (!we) hold_exp[port] = mem_pat(addr[31:2]);
        e.rdata = hold_exp[port];
        sbq.push_back(e);
    endtask

    // Advance one clock, sample after the edge, score any ready pulse
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (cpu_ready || ld_ready) begin
            ready_seen++;
            if (sbq.size() == 0) begin
                chk("unexpected_ready", {62'b0, ld_ready, cpu_ready}, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("ready_owner", {62'b0, ld_ready, cpu_ready}, e.port ? 64'd2 : 64'd1);
                chk("rdata", e.port ? ld_rdata : cpu_rdata, e.rdata);
                $display("txn done: port=%s rdata=0x%08h", e.port ? "LD" : "CPU",
                         e.port ? ld_rdata : cpu_rdata);
            end
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            ld_req = req; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        ld_excl = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sbq.delete();
        hold_exp[0] = '0;
        hold_exp[1] = '0;
    endtask

    // One isolated transaction with exact-latency checks
    task automatic do_txn(input vec_t v);
        int r0;
        r0 = ready_seen;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        expect_txn(v.port, v.we, v.addr);
        tick();
        chk("access_en", mem_en, 1);
        chk("access_we", mem_we, v.we);
        chk("access_addr", mem_addr, v.addr[31:2]);
        if (v.we) chk("access_wdata", mem_wdata, v.wdata);
        chk("ready_not_early", ready_seen - r0, 0);
        // Operands changed after the grant must be ignored
        drive(v.port, 1'b1, ~v.we, 32'hFFFF_FFF0, 32'h0BAD_0BAD);
        tick();
        chk("ready_latency", ready_seen - r0, 1);
        chk("en_low_in_resp", mem_en, 0);
        tick();
        chk("idle_quiet", {mem_en, mem_we, cpu_ready, ld_ready}, 0);
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("sb_drained", sbq.size(), 0);
    endtask

    // Simultaneous CPU read / loader write from a fresh reset
    task automatic tie_seq();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678);
        expect_txn(1'b0, 1'b0, 32'h0000_0000);
        expect_txn(1'b1, 1'b1, 32'h0000_0100);
        tick();
        chk("tie_cpu_first_en", mem_en, 1);
        chk("tie_cpu_first_we", mem_we, 0);
        chk("tie_cpu_first_addr", mem_addr, 0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("tie_ld_en", mem_en, 1);
        chk("tie_ld_we", mem_we, 1);
        chk("tie_ld_addr", mem_addr, 30'h40);
        chk("tie_ld_wdata", mem_wdata, 32'h1234_5678);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("tie_sb_drained", sbq.size(), 0);
        chk("tie_cpu_rdata_held", cpu_rdata, mem_pat(30'h0));
        chk("tie_ld_rdata_unchanged", ld_rdata, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int r0;
        int n;
        int en_cnt;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0};
        vecs[1] = '{port: 1'b1, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0};
        vecs[2] = '{port: 1'b0, we: 1'b1, addr: 32'h0000_0044, wdata: 32'hA5A5_0001};
        vecs[3] = '{port: 1'b1, we: 1'b1, addr: 32'h0000_0100, wdata: 32'h1234_5678};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 32'h0000_002B, wdata: 32'h0};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0};

        do_reset();
        chk("rst_state", {cpu_ready, ld_ready, mem_en, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", {cpu_rdata, ld_rdata}, 0);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Tie right after reset: CPU first
        do_reset();
        tie_seq();

        // Continuous requests on both ports alternate
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        for (int k = 0; k < 6; k++)
            expect_txn(k[0], 1'b0, k[0] ? 32'h0000_0300 : 32'h0000_0200);
        r0 = ready_seen;
        n = 0;
        while ((ready_seen - r0) < 6 && n < 40) begin
            tick();
            n++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("alt_ready_count", ready_seen - r0, 6);
        chk("alt_cycles", n, 17);
        repeat (4) tick();
        chk("alt_no_extra_ready", ready_seen - r0, 6);
        chk("alt_sb_drained", sbq.size(), 0);

        // Loader-exclusive blocks the CPU; release grants on the next edge
        do_reset();
        ld_excl = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        r0 = ready_seen;
        en_cnt = 0;
        repeat (10) begin
            tick();
            if (mem_en) en_cnt++;
        end
        chk("excl_no_grant", en_cnt, 0);
        chk("excl_no_ready", ready_seen - r0, 0);
        ld_excl = 1'b0;
        expect_txn(1'b0, 1'b0, 32'h0000_0080);
        tick();
        chk("excl_release_en", mem_en, 1);
        chk("excl_release_addr", mem_addr, 30'h20);
        tick();
        chk("excl_release_ready", ready_seen - r0, 1);
        tick();

        // Exclusive mode rising mid-transaction lets it finish, then blocks
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0084, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h0000_0084);
        r0 = ready_seen;
        tick();
        chk("excl_mid_en", mem_en, 1);
        ld_excl = 1'b1;
        tick();
        chk("excl_mid_completes", ready_seen - r0, 1);
        en_cnt = 0;
        repeat (4) begin
            tick();
            if (mem_en) en_cnt++;
        end
        chk("excl_mid_then_blocked", en_cnt, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        ld_excl = 1'b0;
        tick();

        // Reset during ACCESS of a loader write aborts it
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
        tick();
        chk("abort_access_en", mem_en, 1);
        reset = 1'b1;
        r0 = ready_seen;
        tick();
        chk("abort_mem_en", mem_en, 0);
        chk("abort_outputs", {cpu_ready, ld_ready, mem_we}, 0);
        chk("abort_mem_bus", {mem_addr, mem_wdata}, 0);
        chk("abort_rdata", {cpu_rdata, ld_rdata}, 0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("abort_no_ready", ready_seen - r0, 0);
        reset = 1'b0;
        sbq.delete();
        hold_exp[0] = '0;
        hold_exp[1] = '0;
        tie_seq();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
